// File: rtl/temp_write_driver.sv
// temp_write_driver: buffers producer bytes in a FIFO and replays each one
// into the temp register as a SETUP / STROBE / HOLD write sequence.
//
// Ports:
//   clk, reset     clock; synchronous active-low reset
//   wr_data/valid  producer byte and valid
//   wr_ready       FIFO has room (combinational from count)
//   stall          blocks the start of a new write sequence (IDLE only)
//   tempData       temp register data (registered)
//   WEtemp         temp register write enable, one-cycle pulse in STROBE
//   busy           FSM not IDLE or FIFO not empty
//   count          FIFO occupancy
//   rb_data        temp register readback   (TEMPWR_READBACK_EN only)
//   rb_error       sticky readback mismatch (TEMPWR_READBACK_EN only)
//
// Optional feature macro: TEMPWR_READBACK_EN
module temp_write_driver #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic                     stall,
    output logic [WIDTH-1:0]         tempData,
    output logic                     WEtemp,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count
`ifdef TEMPWR_READBACK_EN
    ,
    input  logic [WIDTH-1:0]         rb_data,
    output logic                     rb_error
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_STROBE = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nx;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_temp_data;
    logic             r_we;
    logic             w_push;
    logic             w_pop;

    assign wr_ready = (r_count != CW'(DEPTH));
    assign w_push   = wr_valid && wr_ready;
    assign w_pop    = (r_state == S_IDLE) && (r_count != '0) && !stall;

    assign tempData = r_temp_data;
    assign WEtemp   = r_we;
    assign count    = r_count;
    assign busy     = (r_state != S_IDLE) || (r_count != '0);

    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            S_IDLE:   if (w_pop) w_state_nx = S_SETUP;
            S_SETUP:  w_state_nx = S_STROBE;
            S_STROBE: w_state_nx = S_HOLD;
            S_HOLD:   w_state_nx = S_IDLE;
            default:  w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Enable is registered, so it is raised on the edge that enters STROBE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_temp_data <= '0;
            r_we        <= 1'b0;
        end else begin
            if (w_pop) r_temp_data <= r_mem[r_rd_ptr];
            r_we <= (r_state == S_SETUP);
        end
    end

`ifdef TEMPWR_READBACK_EN
    logic r_rb_error;

    assign rb_error = r_rb_error;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rb_error <= 1'b0;
        end else if ((r_state == S_HOLD) && (rb_data != r_temp_data)) begin
            r_rb_error <= 1'b1;
        end
    end
`endif

endmodule
